// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state encoding,
// row-sample helpers and the (column, row) -> hex key map.
// Pure combinational helpers; no latency, no flow control.
package keypad_scanner_pkg;

  localparam int unsigned KP_ROWS = 4;
  localparam int unsigned KP_COLS = 4;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // True when exactly one of the active-low row lines is asserted.
  function automatic logic single_low(input logic [3:0] rs);
    return (rs == 4'b1110) || (rs == 4'b1101) ||
           (rs == 4'b1011) || (rs == 4'b0111);
  endfunction

  // Index of the asserted row; only meaningful when single_low() is true.
  function automatic logic [1:0] low_row(input logic [3:0] rs);
    logic [1:0] idx;
    idx = 2'd0;
    if (!rs[1]) idx = 2'd1;
    if (!rs[2]) idx = 2'd2;
    if (!rs[3]) idx = 2'd3;
    return idx;
  endfunction

  // Physical key legend: column 0 is leftmost, row 0 is the top.
  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] k;
    case ({c, r})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h4;
      4'b00_10: k = 4'h7;
      4'b00_11: k = 4'h0;
      4'b01_00: k = 4'h2;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h8;
      4'b01_11: k = 4'hF;
      4'b10_00: k = 4'h3;
      4'b10_01: k = 4'h6;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hE;
      4'b11_00: k = 4'hA;
      4'b11_01: k = 4'hB;
      4'b11_10: k = 4'hC;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_scanner_prescaler.sv
// Scan-rate tick generator: free-running counter 0..DIV-1, tick while at DIV-1.
// Latency: tick is a decode of the counter register, one clk wide every DIV clks.
// Backpressure: none; the tick is unconditional.
// Ports: clk (rising edge), clr (async active-high reset), tick (1-clk strobe).
module scan_prescaler #(
  parameter int unsigned DIV = 100000
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) count_q <= '0;
    else     count_q <= count_d;
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-key debounce, single-key (no rollover) capture.
// Latency: 2-clk row synchronizer, DEBOUNCE_TICKS stable ticks, key_valid 1 clk after accept.
// Backpressure: none; key_valid is a 1-clk pulse and key holds until the next press.
// Ports: clk, clr (async active-high), row[3:0] keypad rows (active-low, async),
//        col[3:0] one-hot-low column drive, key[3:0] hex code, key_valid pulse, key_held level.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [CNT_W-1:0] DB_TARGET = CNT_W'(DEBOUNCE_TICKS);

  logic             tick;
  logic [3:0]       rs_meta_q;
  logic [3:0]       rs_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       col_q,   col_d;
  logic [1:0]       row_q,   row_d;
  logic [3:0]       key_q,   key_d;
  logic             valid_q, valid_d;
  logic             held_q,  held_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             sample_single;
  logic [1:0]       sample_row;

  scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
    .clk  (clk),
    .clr  (clr),
    .tick (tick)
  );

  // Row lines are asynchronous to clk; only rs_q is used downstream.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rs_meta_q <= 4'b1111;
      rs_q      <= 4'b1111;
    end else begin
      rs_meta_q <= row;
      rs_q      <= rs_meta_q;
    end
  end

  assign sample_single = single_low(rs_q);
  assign sample_row    = low_row(rs_q);
  // Saturating so a huge DEBOUNCE_TICKS can never wrap past the target.
  assign cnt_inc       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // State and datapath registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= SCAN;
      cnt_q   <= '0;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      key_q   <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  // Next-state logic; everything except the key_valid pulse only moves on tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    key_d   = key_q;
    valid_d = 1'b0;
    held_d  = held_q;

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (sample_single) begin
            row_d   = sample_row;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end

        DEBOUNCE: begin
          if (sample_single && (sample_row == row_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_TARGET) begin
              state_d = PRESSED;
              key_d   = key_map(col_q, row_q);
              valid_d = 1'b1;
              held_d  = 1'b1;
            end
          end else begin
            state_d = SCAN;
            col_d   = col_q + 2'd1;
          end
        end

        // Only the latched row matters here; other rows are ignored.
        PRESSED: begin
          if (rs_q[row_q]) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end
        end

        RELEASE: begin
          if (rs_q[row_q]) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_TARGET) begin
              held_d  = 1'b0;
              state_d = SCAN;
              col_d   = col_q + 2'd1;
            end
          end else begin
            // Release bounce: back to PRESSED without a second key_valid.
            state_d = PRESSED;
          end
        end

        default: state_d = SCAN;
      endcase
    end
  end

  // Outputs decode directly from registers.
  always_comb begin
    col       = ~(4'b0001 << col_q);
    key       = key_q;
    key_valid = valid_q;
    key_held  = held_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  // down[c*4+r] = key at column c, row r is physically pressed
  logic [15:0] down;

  int errors    = 0;
  int checks    = 0;
  int valid_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [3:0] sb_exp;
  logic [3:0] exp_q[$];

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DB)) dut (
    .clk       (clk),
    .clr       (clr),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Passive switch matrix: a pressed key shorts its row to its column.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && down[c*4+r]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard side: every accepted key is popped against the queue.
  always @(negedge clk) begin
    if (!clr && key_valid) begin
      valid_cnt++;
      check("valid_pulse_width", 32'(prev_valid), 32'd0);
      if (exp_q.size() > 0) begin
        sb_exp = exp_q.pop_front();
        check("sb_key", 32'(key), 32'(sb_exp));
      end else begin
        check("sb_pending", 32'(exp_q.size()), 32'd1);
      end
    end
    prev_valid = key_valid;
  end

  task automatic run_ticks(input int n);
    repeat (n * SCAN_DIV) @(negedge clk);
  endtask

  // Returns at the first negedge after col freshly becomes target.
  task automatic wait_col(input logic [3:0] target, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (col != target) break;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (col == target) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // Waits up to budget negedges for key_held to reach lvl; returns negedges elapsed (0 = timeout).
  task automatic wait_held(input logic lvl, input int budget, output int at);
    at = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (key_held == lvl) begin
        at = i;
        break;
      end
    end
  endtask

  task automatic col_sweep(input int cycles, output logic [3:0] mask);
    mask = 4'h0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      mask = mask | ~col;
    end
  endtask

  initial begin
    int         v0;
    int         at;
    logic [3:0] mask;

    clr  = 1'b1;
    down = '0;
    repeat (3) @(negedge clk);
    check("rst_col",   32'(col),       32'hE);
    check("rst_key",   32'(key),       32'h0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held",  32'(key_held),  32'd0);
    clr = 1'b0;

    // Press '5' (column 1, row 1) for 40 ticks
    v0 = valid_cnt;
    exp_q.push_back(4'h5);
    down[1*4+1] = 1'b1;
    run_ticks(40);
    check("p5_col",    32'(col),            32'hD);
    check("p5_held",   32'(key_held),       32'd1);
    check("p5_valids", 32'(valid_cnt - v0), 32'd1);
    check("p5_key",    32'(key),            32'h5);

    // Release '5': first tick seeing it is 2..5 clks out, then 3 more ticks
    down = '0;
    wait_held(1'b0, 40, at);
    check("rel_fall_window", 32'((at >= 14) && (at <= 17)), 32'd1);
    if (at < 14 || at > 17) $display("  release fall seen after %0d clks", at);
    check("rel_col",      32'(col), 32'hB);
    check("rel_key_hold", 32'(key), 32'h5);

    // Bounce: 'D' (column 3, row 3) low for two ticks only
    wait_col(4'b0111, "bnc_sync");
    v0 = valid_cnt;
    down[3*4+3] = 1'b1;
    repeat (8) @(negedge clk);
    down = '0;
    col_sweep(48, mask);
    check("bnc_valids", 32'(valid_cnt - v0), 32'd0);
    check("bnc_held",   32'(key_held),       32'd0);
    check("bnc_rotate", 32'(mask),           32'hF);

    // Two rows low together on column 0 ('1' and '7'): never a single sample
    v0 = valid_cnt;
    down[0*4+0] = 1'b1;
    down[0*4+2] = 1'b1;
    col_sweep(80, mask);
    check("dbl_valids", 32'(valid_cnt - v0), 32'd0);
    check("dbl_rotate", 32'(mask),           32'hF);
    check("dbl_held",   32'(key_held),       32'd0);
    down = '0;
    run_ticks(2);

    // Hold 'D' with a one-tick release glitch while pressed
    v0 = valid_cnt;
    exp_q.push_back(4'hD);
    down[3*4+3] = 1'b1;
    wait_held(1'b1, 200, at);
    check("hD_accept", 32'(at != 0), 32'd1);
    run_ticks(2);
    down[3*4+3] = 1'b0;
    repeat (4) @(negedge clk);
    down[3*4+3] = 1'b1;
    run_ticks(10);
    check("hD_valids", 32'(valid_cnt - v0), 32'd1);
    check("hD_held",   32'(key_held),       32'd1);
    check("hD_col",    32'(col),            32'h7);
    down = '0;
    wait_held(1'b0, 60, at);
    check("hD_release", 32'(at != 0), 32'd1);
    check("hD_key",     32'(key),     32'hD);

    // clr while '9' (column 2, row 2) is being debounced
    wait_col(4'b1011, "clr_sync");
    v0 = valid_cnt;
    down[2*4+2] = 1'b1;
    repeat (6) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("clr_col",   32'(col),       32'hE);
    check("clr_key",   32'(key),       32'h0);
    check("clr_valid", 32'(key_valid), 32'd0);
    check("clr_held",  32'(key_held),  32'd0);
    down = '0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("clr_restart_col", 32'(col), 32'hE);
    col_sweep(48, mask);
    check("clr_valids", 32'(valid_cnt - v0), 32'd0);
    check("clr_rotate", 32'(mask),           32'hF);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
